capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/osc_pkg.sv | 16 +
 rtl/trigger_detect.sv | 49 ++++
 rtl/capture_ctrl.sv | 135 +++++++++++++
 tb/tb_capture_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared capture-controller types: FSM state encoding and trigger edge selection.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package osc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage : osc_pkg

// File: rtl/trigger_detect.sv
// Level-crossing trigger: previous-sample register plus threshold comparator.
// Latency: trig_o is combinational on the current sample against the registered previous one.
// Backpressure: none; only valid samples seen while enabled update the history.
module trigger_detect
    import osc_pkg::*;
#(
    parameter int DATA_SIZE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 sample_valid_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic                 trig_edge_i,
    input  logic [DATA_SIZE-1:0] trig_level_i,
    output logic                 trig_o
);

    logic [DATA_SIZE-1:0] prev;
    logic                 prev_vld;
    logic                 above_now;
    logic                 above_prev;

    // Track the last valid sample seen while armed; a new arm forgets history.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if (clear_i) begin
            prev_vld <= 1'b0;
        end else if (enable_i && sample_valid_i) begin
            prev     <= sample_i;
            prev_vld <= 1'b1;
        end
    end

    // Crossing needs both the current and the previous sample to be valid.
    always_comb begin
        above_now  = (sample_i >= trig_level_i);
        above_prev = (prev >= trig_level_i);
        trig_o     = 1'b0;
        if (enable_i && sample_valid_i && prev_vld) begin
            if (trig_edge_i == EDGE_RISE) trig_o = !above_prev && above_now;
            else                          trig_o = above_prev && !above_now;
        end
    end

endmodule : trigger_detect

// File: rtl/capture_ctrl.sv
// Oscilloscope-style capture: arm, wait for level crossing or timeout, write CAPTURE_LEN samples.
// Latency: an accepted sample appears on w_inc_o/w_data_o one cycle later.
// Backpressure: a sample offered while fifo_full_i is high is dropped and flagged in overrun_o.
module capture_ctrl
    import osc_pkg::*;
#(
    parameter int DATA_SIZE    = 4,
    parameter int CAPTURE_LEN  = 8,
    parameter int AUTO_TIMEOUT = 1000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic                 sample_valid_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic                 auto_en_i,
    input  logic                 trig_edge_i,
    input  logic [DATA_SIZE-1:0] trig_level_i,
    input  logic                 fifo_full_i,
    output logic                 w_inc_o,
    output logic [DATA_SIZE-1:0] w_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overrun_o,
    output logic                 auto_trig_o
);

    localparam int SCNT_W = $clog2(CAPTURE_LEN + 1);
    localparam int TCNT_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(CAPTURE_LEN);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(AUTO_TIMEOUT - 1);

    cap_state_t        state;
    cap_state_t        state_nxt;
    logic [SCNT_W-1:0] scnt;
    logic [TCNT_W-1:0] tcnt;
    logic              trig;
    logic              arm_go;
    logic              timeout_hit;
    logic              capture_sel;
    logic              accept;
    logic              drop;
    logic              cap_full;

    trigger_detect #(
        .DATA_SIZE (DATA_SIZE)
    ) u_trig (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (arm_go),
        .enable_i       (state == ST_ARMED),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .trig_edge_i    (trig_edge_i),
        .trig_level_i   (trig_level_i),
        .trig_o         (trig)
    );

    // Qualify arm/timeout/accept. The trigger sample itself is captured from ARMED;
    // once the count reaches CAPTURE_LEN no further sample is taken while heading to DONE.
    always_comb begin
        cap_full    = (scnt == SCNT_LAST);
        arm_go      = arm_i && !abort_i && ((state == ST_IDLE) || (state == ST_DONE));
        timeout_hit = (state == ST_ARMED) && auto_en_i && !trig && (tcnt == TCNT_LAST);
        capture_sel = ((state == ST_CAPTURE) && !cap_full) || ((state == ST_ARMED) && trig);
        accept      = capture_sel && sample_valid_i && !fifo_full_i;
        drop        = capture_sel && sample_valid_i && fifo_full_i;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arm_i) state_nxt = ST_ARMED;
            ST_ARMED:   if (trig || timeout_hit) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (cap_full) state_nxt = ST_DONE;
            ST_DONE:    if (arm_i) state_nxt = ST_ARMED;
            default:    state_nxt = ST_IDLE;
        endcase
        if (abort_i) state_nxt = ST_IDLE;
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy_o = (state == ST_ARMED) || (state == ST_CAPTURE);
        done_o = (state == ST_DONE);
    end

    // Sample and timeout counters, restarted on every arm.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scnt <= '0;
            tcnt <= '0;
        end else if (arm_go) begin
            scnt <= '0;
            tcnt <= '0;
        end else begin
            if (accept) scnt <= scnt + SCNT_W'(1);
            if ((state == ST_ARMED) && auto_en_i && !timeout_hit) tcnt <= tcnt + TCNT_W'(1);
        end
    end

    // Sticky status flags, cleared on arm.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overrun_o   <= 1'b0;
            auto_trig_o <= 1'b0;
        end else if (arm_go) begin
            overrun_o   <= 1'b0;
            auto_trig_o <= 1'b0;
        end else begin
            if (drop)        overrun_o   <= 1'b1;
            if (timeout_hit) auto_trig_o <= 1'b1;
        end
    end

    // Registered FIFO write port; data holds between writes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_inc_o  <= 1'b0;
            w_data_o <= '0;
        end else begin
            w_inc_o <= accept;
            if (accept) w_data_o <= sample_i;
        end
    end

endmodule : capture_ctrl

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [3:0] sample_i = '0;
    logic       sample_valid_i = 1'b0;
    logic       arm_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       auto_en_i = 1'b0;
    logic       trig_edge_i = 1'b0;
    logic [3:0] trig_level_i = 4'd8;
    logic       fifo_full_i = 1'b0;
    logic       w_inc_o;
    logic [3:0] w_data_o;
    logic       busy_o;
    logic       done_o;
    logic       overrun_o;
    logic       auto_trig_o;

    int n_vec = 0;
    int n_err = 0;

    capture_ctrl #(
        .DATA_SIZE    (4),
        .CAPTURE_LEN  (4),
        .AUTO_TIMEOUT (10)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .auto_en_i      (auto_en_i),
        .trig_edge_i    (trig_edge_i),
        .trig_level_i   (trig_level_i),
        .fifo_full_i    (fifo_full_i),
        .w_inc_o        (w_inc_o),
        .w_data_o       (w_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overrun_o      (overrun_o),
        .auto_trig_o    (auto_trig_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then settle 1 time unit past the edge.
    task automatic cyc(input logic v, input logic [3:0] s, input logic a, input logic ab, input logic full);
        sample_valid_i = v;
        sample_i       = s;
        arm_i          = a;
        abort_i        = ab;
        fifo_full_i    = full;
        @(posedge clk_i);
        #1;
    endtask

    // Sample-only cycle, then check the write port.
    task automatic smp(input string tag, input logic [3:0] s, input logic exp_inc, input logic [3:0] exp_dat);
        cyc(1'b1, s, 1'b0, 1'b0, 1'b0);
        chk({tag, "_inc"}, 32'(w_inc_o), 32'(exp_inc));
        if (exp_inc) chk({tag, "_dat"}, 32'(w_data_o), 32'(exp_dat));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_winc"}, 32'(w_inc_o), 32'd0);
        chk({tag, "_wdat"}, 32'(w_data_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_ovr"},  32'(overrun_o), 32'd0);
        chk({tag, "_auto"}, 32'(auto_trig_o), 32'd0);
    endtask

    initial begin
        // Reset state
        rst_i = 1'b0;
        #12;
        chk_all_zero("rst");
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Rising edge, level 8: 3,5,9,10,11,12,13 -> writes 9..12
        trig_edge_i = 1'b0; trig_level_i = 4'd8; auto_en_i = 1'b0;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("r_busy_armed", 32'(busy_o), 32'd1);
        smp("r_s3",  4'd3,  1'b0, 4'd0);
        smp("r_s5",  4'd5,  1'b0, 4'd0);
        smp("r_s9",  4'd9,  1'b1, 4'd9);
        smp("r_s10", 4'd10, 1'b1, 4'd10);
        smp("r_s11", 4'd11, 1'b1, 4'd11);
        smp("r_s12", 4'd12, 1'b1, 4'd12);
        smp("r_s13", 4'd13, 1'b0, 4'd0);
        chk("r_done", 32'(done_o), 32'd1);
        chk("r_busy_done", 32'(busy_o), 32'd0);
        chk("r_hold_dat", 32'(w_data_o), 32'd12);
        smp("r_done_s14", 4'd14, 1'b0, 4'd0);

        // Falling edge, level 8: 12,9,7,2,1,0 -> writes 7,2,1,0
        trig_edge_i = 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("f_busy", 32'(busy_o), 32'd1);
        smp("f_s12", 4'd12, 1'b0, 4'd0);
        smp("f_s9",  4'd9,  1'b0, 4'd0);
        smp("f_s7",  4'd7,  1'b1, 4'd7);
        smp("f_s2",  4'd2,  1'b1, 4'd2);
        smp("f_s1",  4'd1,  1'b1, 4'd1);
        smp("f_s0",  4'd0,  1'b1, 4'd0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("f_done", 32'(done_o), 32'd1);

        // Auto-trigger after 10 ARMED cycles on a constant 2 that never crosses 15
        trig_edge_i = 1'b0; trig_level_i = 4'd15; auto_en_i = 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
            chk($sformatf("a_auto_c%0d", i), 32'(auto_trig_o), (i == 10) ? 32'd1 : 32'd0);
            chk($sformatf("a_winc_c%0d", i), 32'(w_inc_o), 32'd0);
        end
        for (int i = 0; i < 4; i++) smp($sformatf("a_w%0d", i), 4'd2, 1'b1, 4'd2);
        smp("a_after", 4'd2, 1'b0, 4'd0);
        chk("a_done", 32'(done_o), 32'd1);
        chk("a_auto_sticky", 32'(auto_trig_o), 32'd1);

        // Overrun: FIFO full on the 2nd capture sample
        auto_en_i = 1'b0; trig_level_i = 4'd8;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("o_auto_clr", 32'(auto_trig_o), 32'd0);
        smp("o_s3", 4'd3, 1'b0, 4'd0);
        smp("o_s9", 4'd9, 1'b1, 4'd9);
        cyc(1'b1, 4'd10, 1'b0, 1'b0, 1'b1);
        chk("o_drop_inc", 32'(w_inc_o), 32'd0);
        chk("o_ovr", 32'(overrun_o), 32'd1);
        smp("o_s11", 4'd11, 1'b1, 4'd11);
        smp("o_s12", 4'd12, 1'b1, 4'd12);
        smp("o_s13", 4'd13, 1'b1, 4'd13);
        smp("o_s14", 4'd14, 1'b0, 4'd0);
        chk("o_done", 32'(done_o), 32'd1);
        chk("o_ovr_sticky", 32'(overrun_o), 32'd1);

        // Abort together with arm after 2 writes
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("b_ovr_clr", 32'(overrun_o), 32'd0);
        smp("b_s3",  4'd3,  1'b0, 4'd0);
        smp("b_s9",  4'd9,  1'b1, 4'd9);
        smp("b_s10", 4'd10, 1'b1, 4'd10);
        cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("b_busy", 32'(busy_o), 32'd0);
        chk("b_done", 32'(done_o), 32'd0);
        chk("b_winc", 32'(w_inc_o), 32'd0);
        smp("b_s11", 4'd11, 1'b0, 4'd0);
        smp("b_s12", 4'd12, 1'b0, 4'd0);
        chk("b_busy_idle", 32'(busy_o), 32'd0);

        // Reset mid-capture, then a clean restart
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        smp("x_s3",  4'd3,  1'b0, 4'd0);
        smp("x_s9",  4'd9,  1'b1, 4'd9);
        smp("x_s10", 4'd10, 1'b1, 4'd10);
        rst_i = 1'b0;
        #1;
        chk_all_zero("x_rst");
        cyc(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
        chk("x_rst_winc", 32'(w_inc_o), 32'd0);
        rst_i = 1'b1;
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("x_rearm_busy", 32'(busy_o), 32'd1);
        smp("x2_s3",  4'd3,  1'b0, 4'd0);
        smp("x2_s9",  4'd9,  1'b1, 4'd9);
        smp("x2_s10", 4'd10, 1'b1, 4'd10);
        smp("x2_s11", 4'd11, 1'b1, 4'd11);
        smp("x2_s12", 4'd12, 1'b1, 4'd12);
        smp("x2_s13", 4'd13, 1'b0, 4'd0);
        chk("x2_done", 32'(done_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_capture_ctrl
